// File: rtl/mem_port_arbiter.sv
// Three-requester arbiter for one port of the shared dual-port RAM.
// Requester 0 (display scan-out) has absolute priority; requesters 1 and 2
// share the remaining cycles round-robin with a bounded burst length.
module mem_port_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10,
    parameter int BURST_MAX  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  we0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic                  req1,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata1,
    input  logic                  req2,
    input  logic                  we2,
    input  logic [ADDR_WIDTH-1:0] addr2,
    input  logic [DATA_WIDTH-1:0] wdata2,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  gnt2,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic                  rvalid2,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_dout
);

    localparam int BW = $clog2(BURST_MAX + 1);
    localparam logic [BW-1:0] BMAX = BW'(BURST_MAX);
    localparam logic [BW-1:0] ONE  = BW'(1);

    typedef enum logic [1:0] {
        IDLE,
        OWN1,
        OWN2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [BW-1:0]   bcnt;
    logic [BW-1:0]   bcnt_nxt;
    logic            g0;
    logic            g1;
    logic            g2;
    logic [2:0]      rv_q;

    // Grant decision and next round-robin state for the current cycle.
    always_comb begin
        g0        = 1'b0;
        g1        = 1'b0;
        g2        = 1'b0;
        state_nxt = state;
        bcnt_nxt  = bcnt;
        if (reset) begin
            state_nxt = IDLE;
            bcnt_nxt  = '0;
        end else if (req0) begin
            // Preemption: round-robin state and burst count hold.
            g0 = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (req1) begin
                        g1        = 1'b1;
                        state_nxt = OWN1;
                        bcnt_nxt  = ONE;
                    end else if (req2) begin
                        g2        = 1'b1;
                        state_nxt = OWN2;
                        bcnt_nxt  = ONE;
                    end
                end
                OWN1: begin
                    if (req1 && ((bcnt < BMAX) || !req2)) begin
                        g1       = 1'b1;
                        bcnt_nxt = (bcnt == BMAX) ? bcnt : bcnt + ONE;
                    end else if (req2) begin
                        g2        = 1'b1;
                        state_nxt = OWN2;
                        bcnt_nxt  = ONE;
                    end else begin
                        state_nxt = IDLE;
                        bcnt_nxt  = '0;
                    end
                end
                OWN2: begin
                    if (req2 && ((bcnt < BMAX) || !req1)) begin
                        g2       = 1'b1;
                        bcnt_nxt = (bcnt == BMAX) ? bcnt : bcnt + ONE;
                    end else if (req1) begin
                        g1        = 1'b1;
                        state_nxt = OWN1;
                        bcnt_nxt  = ONE;
                    end else begin
                        state_nxt = IDLE;
                        bcnt_nxt  = '0;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    bcnt_nxt  = '0;
                end
            endcase
        end
    end

    // Arbiter state and one-cycle-delayed read strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            bcnt  <= '0;
            rv_q  <= '0;
        end else begin
            state <= state_nxt;
            bcnt  <= bcnt_nxt;
            rv_q  <= {g2 & ~we2, g1 & ~we1, g0 & ~we0};
        end
    end

    // Route the granted requester onto the RAM port.
    always_comb begin
        mem_addr = addr0;
        mem_din  = '0;
        mem_we   = 1'b0;
        if (g0) begin
            mem_addr = addr0;
            mem_din  = wdata0;
            mem_we   = we0;
        end else if (g1) begin
            mem_addr = addr1;
            mem_din  = wdata1;
            mem_we   = we1;
        end else if (g2) begin
            mem_addr = addr2;
            mem_din  = wdata2;
            mem_we   = we2;
        end
    end

    assign gnt0 = g0;
    assign gnt1 = g1;
    assign gnt2 = g2;

    // Gating with reset drops a read whose response would land in a reset cycle.
    assign rvalid0 = rv_q[0] & ~reset;
    assign rvalid1 = rv_q[1] & ~reset;
    assign rvalid2 = rv_q[2] & ~reset;

    assign rdata = mem_dout;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter with a RAM model and a read scoreboard.
module tb_mem_port_arbiter;

    localparam int DW = 16;
    localparam int AW = 10;

    logic          clk;
    logic          reset;
    logic          req0, req1, req2;
    logic          we0, we1, we2;
    logic [AW-1:0] addr0, addr1, addr2;
    logic [DW-1:0] wdata0, wdata1, wdata2;
    logic          gnt0, gnt1, gnt2;
    logic          rvalid0, rvalid1, rvalid2;
    logic [DW-1:0] rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic          mem_we;
    logic [DW-1:0] mem_dout;

    int n_chk;
    int n_fail;
    int cyc;

    typedef struct {
        int unsigned id;
        logic [DW-1:0] data;
        int cyc;
    } exp_t;
    exp_t sb[$];

    logic [DW-1:0] ram    [1024];
    logic [DW-1:0] shadow [1024];
    logic [AW-1:0] ram_raddr;

    mem_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_MAX(4)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .req2(req2), .we2(we2), .addr2(addr2), .wdata2(wdata2),
        .gnt0(gnt0), .gnt1(gnt1), .gnt2(gnt2),
        .rvalid0(rvalid0), .rvalid1(rvalid1), .rvalid2(rvalid2),
        .rdata(rdata), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_we(mem_we), .mem_dout(mem_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // RAM port: registered read address, combinational read data.
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_din;
        ram_raddr <= mem_addr;
    end
    assign mem_dout = ram[ram_raddr];

    // Read-response scoreboard: each granted read expects its strobe one cycle later.
    always @(negedge clk) begin
        logic [2:0] rv;
        exp_t e;
        rv = {rvalid2, rvalid1, rvalid0};
        n_chk++;
        if (sb.size() > 0 && sb[0].cyc <= cyc - 1) begin
            e = sb.pop_front();
            if (rv !== (3'b001 << e.id) || rdata !== e.data) begin
                n_fail++;
                $display("FAIL rvalid_data cyc=%0d got rvalid=%b rdata=%h expected rvalid=%b rdata=%h",
                         cyc, rv, rdata, 3'b001 << e.id, e.data);
            end
        end else if (rv !== 3'b000) begin
            n_fail++;
            $display("FAIL unexpected_rvalid cyc=%0d got rvalid=%b expected 000", cyc, rv);
        end
    end

    task automatic clear_inputs();
        req0 = 0; req1 = 0; req2 = 0;
        we0 = 0; we1 = 0; we2 = 0;
        addr0 = '0; addr1 = '0; addr2 = '0;
        wdata0 = '0; wdata1 = '0; wdata2 = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1; req0 = 1; we0 = 1; req1 = 1; addr0 = 10'h3FF;
        @(negedge clk);
        n_chk++;
        if ({gnt2, gnt1, gnt0} !== 3'b000 || mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_gnt got gnt=%b mem_we=%b expected gnt=000 mem_we=0",
                     {gnt2, gnt1, gnt0}, mem_we);
        end
        next_cycle();
        next_cycle();
        clear_inputs();
        reset = 0;
        @(negedge clk);
        n_chk++;
        if ({gnt2, gnt1, gnt0} !== 3'b000 || mem_we !== 1'b0 || mem_addr !== 10'h000 || mem_din !== 16'h0000) begin
            n_fail++;
            $display("FAIL idle_port got gnt=%b we=%b addr=%h din=%h expected 000 0 000 0000",
                     {gnt2, gnt1, gnt0}, mem_we, mem_addr, mem_din);
        end
        next_cycle();
    endtask

    task automatic test_read_after_write();
        clear_inputs();
        req1 = 1; we1 = 1; addr1 = 10'h005; wdata1 = 16'hBEEF;
        @(negedge clk);
        n_chk++;
        if ({gnt2, gnt1, gnt0} !== 3'b010 || mem_we !== 1'b1 || mem_addr !== 10'h005 || mem_din !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL raw_write got gnt=%b we=%b addr=%h din=%h expected 010 1 005 beef",
                     {gnt2, gnt1, gnt0}, mem_we, mem_addr, mem_din);
        end
        shadow[5] = 16'hBEEF;
        next_cycle();
        we1 = 0; wdata1 = '0;
        @(negedge clk);
        n_chk++;
        if ({gnt2, gnt1, gnt0} !== 3'b010 || mem_we !== 1'b0 || mem_addr !== 10'h005) begin
            n_fail++;
            $display("FAIL raw_read got gnt=%b we=%b addr=%h expected 010 0 005",
                     {gnt2, gnt1, gnt0}, mem_we, mem_addr);
        end
        sb.push_back('{id: 1, data: 16'hBEEF, cyc: cyc});
        next_cycle();
        clear_inputs();
        next_cycle();
    endtask

    task automatic test_preempt();
        int unsigned after[3] = '{1, 1, 2};
        logic [2:0] g;
        clear_inputs();
        // Two grants to requester 1 leave OWN1 with bcnt=2.
        for (int i = 0; i < 2; i++) begin
            req1 = 1; addr1 = AW'(10'h020 + i);
            @(negedge clk);
            n_chk++;
            if ({gnt2, gnt1, gnt0} !== 3'b010) begin
                n_fail++;
                $display("FAIL preempt_setup i=%0d got gnt=%b expected 010", i, {gnt2, gnt1, gnt0});
            end
            sb.push_back('{id: 1, data: shadow[10'h020 + i], cyc: cyc});
            next_cycle();
        end
        for (int i = 0; i < 6; i++) begin
            req0 = 1; req1 = 1; req2 = 1;
            addr0 = AW'(10'h050 + i); addr1 = 10'h0AA; addr2 = 10'h0BB;
            @(negedge clk);
            n_chk++;
            if ({gnt2, gnt1, gnt0} !== 3'b001 || mem_addr !== AW'(10'h050 + i)) begin
                n_fail++;
                $display("FAIL preempt i=%0d got gnt=%b addr=%h expected 001 %h",
                         i, {gnt2, gnt1, gnt0}, mem_addr, AW'(10'h050 + i));
            end
            sb.push_back('{id: 0, data: shadow[10'h050 + i], cyc: cyc});
            next_cycle();
        end
        // Held bcnt=2: two more grants to 1, then yield to 2.
        req0 = 0;
        for (int i = 0; i < 3; i++) begin
            addr1 = AW'(10'h060 + i); addr2 = AW'(10'h070 + i);
            @(negedge clk);
            g = 3'b001 << after[i];
            n_chk++;
            if ({gnt2, gnt1, gnt0} !== g) begin
                n_fail++;
                $display("FAIL preempt_resume i=%0d got gnt=%b expected %b", i, {gnt2, gnt1, gnt0}, g);
            end
            sb.push_back('{id: after[i], data: (after[i] == 1) ? shadow[10'h060 + i] : shadow[10'h070 + i], cyc: cyc});
            next_cycle();
        end
        clear_inputs();
        next_cycle();
    endtask

    task automatic test_fairness();
        int unsigned seq[10] = '{1, 1, 1, 1, 2, 2, 2, 2, 1, 1};
        logic [2:0]    g;
        logic [AW-1:0] a;
        clear_inputs();
        for (int i = 0; i < 10; i++) begin
            req1 = 1; req2 = 1;
            addr1 = AW'(10'h100 + i); addr2 = AW'(10'h200 + i);
            @(negedge clk);
            g = 3'b001 << seq[i];
            a = (seq[i] == 1) ? addr1 : addr2;
            n_chk++;
            if ({gnt2, gnt1, gnt0} !== g || mem_addr !== a) begin
                n_fail++;
                $display("FAIL fairness i=%0d got gnt=%b addr=%h expected %b %h",
                         i, {gnt2, gnt1, gnt0}, mem_addr, g, a);
            end
            sb.push_back('{id: seq[i], data: shadow[a], cyc: cyc});
            next_cycle();
        end
        clear_inputs();
        next_cycle();
    endtask

    task automatic test_interleave();
        clear_inputs();
        ram[16'h10] = 16'h1111; shadow[16'h10] = 16'h1111;
        ram[16'h11] = 16'h2222; shadow[16'h11] = 16'h2222;
        req0 = 1; addr0 = 10'h010; req1 = 1; addr1 = 10'h011;
        @(negedge clk);
        n_chk++;
        if ({gnt2, gnt1, gnt0} !== 3'b001 || mem_addr !== 10'h010) begin
            n_fail++;
            $display("FAIL interleave_n got gnt=%b addr=%h expected 001 010", {gnt2, gnt1, gnt0}, mem_addr);
        end
        sb.push_back('{id: 0, data: 16'h1111, cyc: cyc});
        next_cycle();
        req0 = 0;
        @(negedge clk);
        n_chk++;
        if ({gnt2, gnt1, gnt0} !== 3'b010 || mem_addr !== 10'h011) begin
            n_fail++;
            $display("FAIL interleave_n1 got gnt=%b addr=%h expected 010 011", {gnt2, gnt1, gnt0}, mem_addr);
        end
        sb.push_back('{id: 1, data: 16'h2222, cyc: cyc});
        next_cycle();
        clear_inputs();
        next_cycle();
    endtask

    task automatic test_reset_mid_read();
        clear_inputs();
        req2 = 1; addr2 = 10'h030;
        @(negedge clk);
        n_chk++;
        if ({gnt2, gnt1, gnt0} !== 3'b100) begin
            n_fail++;
            $display("FAIL midread_gnt got gnt=%b expected 100", {gnt2, gnt1, gnt0});
        end
        next_cycle();
        clear_inputs();
        reset = 1; req2 = 1; we2 = 1; addr2 = 10'h031;
        @(negedge clk);
        n_chk++;
        if (rvalid2 !== 1'b0 || mem_we !== 1'b0 || {gnt2, gnt1, gnt0} !== 3'b000) begin
            n_fail++;
            $display("FAIL midread_reset got rvalid2=%b mem_we=%b gnt=%b expected 0 0 000",
                     rvalid2, mem_we, {gnt2, gnt1, gnt0});
        end
        next_cycle();
        clear_inputs();
        reset = 0;
        req1 = 1; req2 = 1; addr1 = 10'h032; addr2 = 10'h033;
        @(negedge clk);
        n_chk++;
        if ({gnt2, gnt1, gnt0} !== 3'b010) begin
            n_fail++;
            $display("FAIL post_reset_first got gnt=%b expected 010", {gnt2, gnt1, gnt0});
        end
        sb.push_back('{id: 1, data: shadow[10'h032], cyc: cyc});
        next_cycle();
        clear_inputs();
        next_cycle();
    endtask

    task automatic test_lone_requester();
        logic [DW-1:0] d;
        clear_inputs();
        for (int i = 0; i < 8; i++) begin
            d = DW'($urandom);
            req2 = 1; we2 = 1; addr2 = AW'(10'h040 + i); wdata2 = d;
            @(negedge clk);
            n_chk++;
            if ({gnt2, gnt1, gnt0} !== 3'b100 || mem_we !== 1'b1 || mem_din !== d) begin
                n_fail++;
                $display("FAIL lone i=%0d got gnt=%b we=%b din=%h expected 100 1 %h",
                         i, {gnt2, gnt1, gnt0}, mem_we, mem_din, d);
            end
            shadow[10'h040 + i] = d;
            next_cycle();
        end
        clear_inputs();
        addr0 = 10'h123;
        @(negedge clk);
        n_chk++;
        if ({gnt2, gnt1, gnt0} !== 3'b000 || mem_we !== 1'b0 || mem_addr !== 10'h123) begin
            n_fail++;
            $display("FAIL release got gnt=%b we=%b addr=%h expected 000 0 123",
                     {gnt2, gnt1, gnt0}, mem_we, mem_addr);
        end
        next_cycle();
        // Read back two of the written words from IDLE, both requesters asking.
        req1 = 1; addr1 = 10'h043; req2 = 1; addr2 = 10'h047;
        @(negedge clk);
        n_chk++;
        if ({gnt2, gnt1, gnt0} !== 3'b010) begin
            n_fail++;
            $display("FAIL readback_first got gnt=%b expected 010", {gnt2, gnt1, gnt0});
        end
        sb.push_back('{id: 1, data: shadow[10'h043], cyc: cyc});
        next_cycle();
        req1 = 0;
        @(negedge clk);
        n_chk++;
        if ({gnt2, gnt1, gnt0} !== 3'b100) begin
            n_fail++;
            $display("FAIL readback_second got gnt=%b expected 100", {gnt2, gnt1, gnt0});
        end
        sb.push_back('{id: 2, data: shadow[10'h047], cyc: cyc});
        next_cycle();
        clear_inputs();
        next_cycle();
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        cyc    = 0;
        for (int i = 0; i < 1024; i++) begin
            ram[i]    = DW'($urandom);
            shadow[i] = ram[i];
        end
        ram_raddr = '0;
        test_reset();
        test_read_after_write();
        test_preempt();
        test_fairness();
        test_interleave();
        test_reset_mid_read();
        test_lone_requester();
        repeat (3) next_cycle();
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got %0d pending reads expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, 16, word width; ADDR_WIDTH, 10, word address width; BURST_MAX, 4, max consecutive grants to one round-robin requester while the other round-robin requester waits.
REQ-002 Ports SHALL be: clk  in  1  sole clock, rising edge; reset  in  1  synchronous, active-high reset.
REQ-003 Ports SHALL be, for k in 0..2: reqk  in  1  access request; wek  in  1  write (1) or read (0), qualified by reqk; addrk  in  ADDR_WIDTH  word address; wdatak  in  DATA_WIDTH  write data.
REQ-004 Ports SHALL be, for k in 0..2: gntk  out  1  access accepted this cycle; rvalidk  out  1  read data for requester k on rdata this cycle.
REQ-005 Ports SHALL be: rdata  out  DATA_WIDTH  read data shared by all requesters; mem_addr  out  ADDR_WIDTH; mem_din  out  DATA_WIDTH; mem_we  out  1; mem_dout  in  DATA_WIDTH; these connect to one port of the team dual-port RAM, whose read address is registered at clk and whose read data is combinational from that registered address.

Function
REQ-006 At most one gntk SHALL be high per cycle; gntk is combinational from the current cycle's req inputs and registered arbiter state.
REQ-007 req0 (display scan-out) SHALL have fixed highest priority and is granted in every cycle it is high.
REQ-008 req1 and req2 SHALL share the remaining cycles under a round-robin FSM with states IDLE, OWN1, OWN2 and a burst counter bcnt (0..BURST_MAX).
REQ-009 When req0 is low: in IDLE, grant req1 if high, else req2 if high, and move to OWN1/OWN2 respectively.
REQ-010 In OWNk with reqk high and (bcnt < BURST_MAX or other requester low): keep granting k.
REQ-011 In OWNk with the other requester high and (reqk low or bcnt = BURST_MAX): grant the other requester and switch state.
REQ-012 In OWNk with req1 and req2 both low: no grant; next state IDLE.
REQ-013 bcnt SHALL increment (saturating at BURST_MAX) on each cycle gnt1/gnt2 goes to the current owner, and SHALL load 1 on an ownership change, 0 on entering IDLE.
REQ-014 A cycle in which req0 preempts SHALL leave state and bcnt unchanged.
REQ-015 Granted requester k SHALL drive mem_addr=addrk, mem_din=wdatak, mem_we=wek in the same cycle; with no grant, mem_we=0, mem_addr=addr0, mem_din=0.
REQ-016 Writes SHALL complete at the clk edge ending the grant cycle; no response strobe is produced for writes.
REQ-017 A read granted in cycle N SHALL yield rvalidk=1 and rdata=mem_dout in cycle N+1 only; rvalid for other requesters is 0 that cycle.
REQ-018 Back-to-back reads from any mix of requesters SHALL sustain one access per cycle with no bubbles.
REQ-019 rdata SHALL equal mem_dout at all times; it is meaningful only when some rvalidk is high.

Reset
REQ-020 While reset is high at a clk edge, the next cycle SHALL have: state IDLE, bcnt 0, all rvalidk 0; gntk remain combinational but SHALL be forced 0 and mem_we 0 in any cycle reset is high.
REQ-021 A read granted in the cycle before reset asserts SHALL NOT produce rvalid.
REQ-022 After reset deasserts, the first arbitration SHALL follow IDLE rules (req1 favoured).

Verification
REQ-023 Read after write: req1 we1=1 addr1=0x005 wdata1=0xBEEF, next cycle req1 read addr 0x005 -> gnt1 both cycles, rvalid1 and rdata=0xBEEF one cycle after the read grant.
REQ-024 Preemption: req0, req1 and req2 held high for 6 cycles -> gnt0 all 6 cycles, gnt1/gnt2 never high, state/bcnt unchanged.
REQ-025 Fairness: req1 and req2 held high 10 cycles (BURST_MAX=4) from IDLE -> grant sequence 1,1,1,1,2,2,2,2,1,1.
REQ-026 Interleaved reads: cycle N gnt0 addr 0x010 (mem 0x1111), N+1 gnt1 addr 0x011 (mem 0x2222) -> N+1 rvalid0 rdata=0x1111, N+2 rvalid1 rdata=0x2222.
REQ-027 Reset mid-read: read gnt2 in cycle N, reset high in cycle N+1 -> rvalid2 stays 0, mem_we 0; post-reset req1 and req2 together -> gnt1 first.
REQ-028 Idle/lone requester: req2 alone held 8 cycles -> gnt2 every cycle (no forced yield); release both -> state IDLE next cycle, mem_we 0.
